// File: rtl/template_fetch.sv
// template_fetch: fetches one letter template (WORDS 16-bit words) from an
// SRAM controller using a request / wait-high / wait-low handshake and
// buffers the words in a small circular FIFO for a downstream consumer.
module template_fetch #(
    parameter int WORDS      = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [4:0]  i_letter_idx,
    input  logic        i_pop,
    output logic [15:0] o_data,
    output logic        o_valid,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic        o_mem_req,
    output logic        o_mem_wr,
    output logic [19:0] o_mem_addr,
    input  logic        i_mem_wait,
    input  logic [15:0] i_mem_rdata
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_ACK,
        S_DRAIN,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t         r_state;
    logic [4:0]     r_letter;
    logic [3:0]     r_word;
    logic [TW-1:0]  r_tcnt;
    logic           r_mem_req;
    logic [19:0]    r_mem_addr;
    logic           r_done;
    logic           r_err;

    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic [15:0]    r_fifo_mem [FIFO_DEPTH];

    logic           w_push;
    logic           w_pop;
    logic           w_full;
    logic           w_flush;
    logic           w_tmo_hit;

    // FIFO control decoded from the FSM state and the consumer
    assign w_push    = (r_state == S_CAPTURE);
    assign w_pop     = i_pop && (r_count != '0);
    assign w_full    = (r_count == CW'(FIFO_DEPTH));
    assign w_tmo_hit = (r_tcnt == TW'(TIMEOUT - 1));
    // A stuck handshake abandons the letter and discards what was buffered
    assign w_flush   = w_tmo_hit &&
                       (((r_state == S_ACK) && !i_mem_wait) ||
                        ((r_state == S_DRAIN) && i_mem_wait));

    // Circular pointer advance that wraps at FIFO_DEPTH (depth need not be 2^n)
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Main fetch FSM with registered handshake and status outputs
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state    <= S_IDLE;
            r_letter   <= '0;
            r_word     <= '0;
            r_tcnt     <= '0;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_mem_req <= 1'b0;
            r_done    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        if (i_letter_idx <= 5'd25) begin
                            r_letter <= i_letter_idx;
                            r_word   <= '0;
                            r_err    <= 1'b0;
                            r_state  <= S_ISSUE;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    // Only ask for a word when there is room to store it
                    if (!w_full) begin
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= {5'b0, r_letter, 6'b0, r_word};
                        r_tcnt     <= '0;
                        r_state    <= S_ACK;
                    end
                end
                S_ACK: begin
                    if (i_mem_wait) begin
                        r_tcnt  <= '0;
                        r_state <= S_DRAIN;
                    end else if (w_tmo_hit) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (!i_mem_wait) begin
                        r_state <= S_CAPTURE;
                    end else if (w_tmo_hit) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    if (r_word == 4'(WORDS - 1)) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_word  <= r_word + 1'b1;
                        r_state <= S_ISSUE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // FIFO pointers and occupancy; push and pop together leave count unchanged
    always_ff @(posedge i_clk) begin
        if (!i_rst || w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; contents need no reset because o_data is gated by count
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr] <= i_mem_rdata;
        end
    end

    assign o_data     = (r_count != '0) ? r_fifo_mem[r_rd_ptr] : 16'h0000;
    assign o_valid    = (r_count != '0);
    assign o_busy     = (r_state != S_IDLE);
    assign o_done     = r_done;
    assign o_err      = r_err;
    assign o_mem_req  = r_mem_req;
    assign o_mem_wr   = 1'b1;
    assign o_mem_addr = r_mem_addr;

endmodule
